// File: rtl/roce_write_wr_scheduler_if.sv
`default_nettype none
// ============================================================================
// roce_write_wr_scheduler_if : WR metadata in, per-packet descriptors out
// Rev 1.0
// ============================================================================
interface roce_write_wr_scheduler_if;
    logic        cfg_valid;
    logic        cfg_start;
    logic        cfg_write_imm;
    logic [31:0] cfg_dma_length;
    logic [63:0] cfg_rem_addr;
    logic [31:0] cfg_r_key;
    logic [23:0] cfg_rem_qpn;
    logic [23:0] cfg_loc_psn;
    logic [31:0] cfg_rem_ip_addr;
    logic [31:0] cfg_imm_data;
    logic [2:0]  cfg_pmtu_code;

    logic        m_desc_valid;
    logic        m_desc_ready;
    logic [7:0]  m_desc_opcode;
    logic [23:0] m_desc_psn;
    logic [23:0] m_desc_dest_qp;
    logic        m_desc_reth_valid;
    logic [63:0] m_desc_rem_addr;
    logic [31:0] m_desc_r_key;
    logic [31:0] m_desc_dma_length;
    logic        m_desc_imm_valid;
    logic [31:0] m_desc_imm_data;
    logic [31:0] m_desc_ip_addr;
    logic [12:0] m_desc_payload_len;

    logic [23:0] next_psn;
    logic        busy;
    logic        wr_done;
    logic        cfg_overrun;

    modport master (
        input  cfg_valid, cfg_start, cfg_write_imm, cfg_dma_length, cfg_rem_addr,
               cfg_r_key, cfg_rem_qpn, cfg_loc_psn, cfg_rem_ip_addr, cfg_imm_data,
               cfg_pmtu_code, m_desc_ready,
        output m_desc_valid, m_desc_opcode, m_desc_psn, m_desc_dest_qp,
               m_desc_reth_valid, m_desc_rem_addr, m_desc_r_key, m_desc_dma_length,
               m_desc_imm_valid, m_desc_imm_data, m_desc_ip_addr, m_desc_payload_len,
               next_psn, busy, wr_done, cfg_overrun
    );

    modport slave (
        output cfg_valid, cfg_start, cfg_write_imm, cfg_dma_length, cfg_rem_addr,
               cfg_r_key, cfg_rem_qpn, cfg_loc_psn, cfg_rem_ip_addr, cfg_imm_data,
               cfg_pmtu_code, m_desc_ready,
        input  m_desc_valid, m_desc_opcode, m_desc_psn, m_desc_dest_qp,
               m_desc_reth_valid, m_desc_rem_addr, m_desc_r_key, m_desc_dma_length,
               m_desc_imm_valid, m_desc_imm_data, m_desc_ip_addr, m_desc_payload_len,
               next_psn, busy, wr_done, cfg_overrun
    );
endinterface
`default_nettype wire

// File: rtl/roce_write_wr_scheduler.sv
`default_nettype none
// ============================================================================
// roce_write_wr_scheduler : splits one RDMA WRITE WR into PMTU-sized descriptors
// Rev 1.0
// ============================================================================
module roce_write_wr_scheduler #(
    parameter int DEFAULT_PMTU_CODE = 3
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    roce_write_wr_scheduler_if.master       bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    localparam logic [12:0] c_default_pmtu = 13'(256 << (DEFAULT_PMTU_CODE - 1));

    function automatic logic [12:0] pmtu_bytes(input logic [2:0] code);
        case (code)
            3'd1:    pmtu_bytes = 13'd256;
            3'd2:    pmtu_bytes = 13'd512;
            3'd3:    pmtu_bytes = 13'd1024;
            3'd4:    pmtu_bytes = 13'd2048;
            3'd5:    pmtu_bytes = 13'd4096;
            default: pmtu_bytes = c_default_pmtu;
        endcase
    endfunction

    state_t      r_state, w_state_n;
    logic [31:0] r_remaining;
    logic [23:0] r_psn;
    logic        r_first;
    logic [12:0] r_pmtu;
    logic        r_write_imm;
    logic [31:0] r_dma_length;
    logic [63:0] r_rem_addr;
    logic [31:0] r_r_key;
    logic [23:0] r_rem_qpn;
    logic [31:0] r_rem_ip;
    logic [31:0] r_imm_data;
    logic        r_desc_valid;
    logic [23:0] r_next_psn;
    logic        r_wr_done;
    logic        r_overrun;

    logic        w_load, w_launch, w_accept, w_finish;
    logic        w_is_last;
    logic [12:0] w_payload;
    logic [7:0]  w_opcode;

    // Payload never exceeds the PMTU, so the low 13 bits hold the whole tail.
    assign w_is_last = (r_remaining <= {19'd0, r_pmtu});
    assign w_payload = w_is_last ? r_remaining[12:0] : r_pmtu;

    always_comb begin
        if (r_first)
            w_opcode = w_is_last ? (r_write_imm ? 8'h0B : 8'h0A) : 8'h06;
        else
            w_opcode = w_is_last ? (r_write_imm ? 8'h09 : 8'h08) : 8'h07;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_launch  = 1'b0;
        w_accept  = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    w_load = 1'b1;
                    if (bus.cfg_start) begin
                        w_launch  = 1'b1;
                        w_state_n = S_SEND;
                    end else begin
                        w_state_n = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                w_load = bus.cfg_valid;
                if (bus.cfg_start) begin
                    w_launch  = 1'b1;
                    w_state_n = S_SEND;
                end
            end
            S_SEND: begin
                w_accept = r_desc_valid && bus.m_desc_ready;
                if (w_accept && w_is_last) begin
                    w_finish  = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining  <= 32'd0;
            r_psn        <= 24'd0;
            r_first      <= 1'b0;
            r_pmtu       <= 13'd0;
            r_write_imm  <= 1'b0;
            r_dma_length <= 32'd0;
            r_rem_addr   <= 64'd0;
            r_r_key      <= 32'd0;
            r_rem_qpn    <= 24'd0;
            r_rem_ip     <= 32'd0;
            r_imm_data   <= 32'd0;
            r_desc_valid <= 1'b0;
            r_next_psn   <= 24'd0;
            r_wr_done    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            r_overrun <= bus.cfg_valid && (r_state == S_SEND);
            if (w_load) begin
                r_remaining  <= bus.cfg_dma_length;
                r_psn        <= bus.cfg_loc_psn;
                r_first      <= 1'b1;
                r_pmtu       <= pmtu_bytes(bus.cfg_pmtu_code);
                r_write_imm  <= bus.cfg_write_imm;
                r_dma_length <= bus.cfg_dma_length;
                r_rem_addr   <= bus.cfg_rem_addr;
                r_r_key      <= bus.cfg_r_key;
                r_rem_qpn    <= bus.cfg_rem_qpn;
                r_rem_ip     <= bus.cfg_rem_ip_addr;
                r_imm_data   <= bus.cfg_imm_data;
            end
            if (w_launch)
                r_desc_valid <= 1'b1;
            if (w_accept) begin
                r_psn       <= r_psn + 24'd1;
                r_remaining <= r_remaining - {19'd0, w_payload};
                r_first     <= 1'b0;
            end
            if (w_finish) begin
                r_desc_valid <= 1'b0;
                r_wr_done    <= 1'b1;
                r_next_psn   <= r_psn + 24'd1;
            end
        end
    end

    // Descriptor fields read as zero whenever no descriptor is offered.
    assign bus.m_desc_valid       = r_desc_valid;
    assign bus.m_desc_opcode      = r_desc_valid ? w_opcode : 8'h00;
    assign bus.m_desc_psn         = r_desc_valid ? r_psn : 24'd0;
    assign bus.m_desc_dest_qp     = r_desc_valid ? r_rem_qpn : 24'd0;
    assign bus.m_desc_reth_valid  = r_desc_valid && r_first;
    assign bus.m_desc_rem_addr    = r_desc_valid ? r_rem_addr : 64'd0;
    assign bus.m_desc_r_key       = r_desc_valid ? r_r_key : 32'd0;
    assign bus.m_desc_dma_length  = r_desc_valid ? r_dma_length : 32'd0;
    assign bus.m_desc_imm_valid   = r_desc_valid && r_write_imm && w_is_last;
    assign bus.m_desc_imm_data    = r_desc_valid ? r_imm_data : 32'd0;
    assign bus.m_desc_ip_addr     = r_desc_valid ? r_rem_ip : 32'd0;
    assign bus.m_desc_payload_len = r_desc_valid ? w_payload : 13'd0;
    assign bus.next_psn           = r_next_psn;
    assign bus.busy               = (r_state != S_IDLE);
    assign bus.wr_done            = r_wr_done;
    assign bus.cfg_overrun        = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_roce_write_wr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_roce_write_wr_scheduler : directed scoreboard bench for the WR scheduler
// Rev 1.0
// ============================================================================
module tb_roce_write_wr_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    roce_write_wr_scheduler_if bus();
    roce_write_wr_scheduler #(.DEFAULT_PMTU_CODE(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] psn;
        logic [12:0] plen;
        logic        reth;
        logic        imm;
        logic [63:0] addr;
        logic [31:0] rkey;
        logic [31:0] dma;
        logic [23:0] qpn;
        logic [31:0] ip;
        logic [31:0] immd;
    } desc_t;

    desc_t       q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          n_ovr = 0;
    int          exp_done = 0;
    logic [23:0] exp_np;
    int          ready_mode = 0;
    logic        have_snap = 1'b0;
    logic [46:0] snap_a;
    logic [63:0] snap_b;

    // Sole driver of m_desc_ready: 0 = always ready, 1 = random stalls, 2 = never
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.m_desc_ready = 1'b1;
            1:       bus.m_desc_ready = ($urandom_range(0, 3) != 0);
            default: bus.m_desc_ready = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT shows there.
    task automatic step();
        desc_t d;
        @(negedge clk);
        if (!rst) begin
            if (bus.wr_done)     n_done++;
            if (bus.cfg_overrun) n_ovr++;
            if (have_snap) begin
                check("stall_hold_fields", {17'd0, bus.m_desc_opcode, bus.m_desc_psn, bus.m_desc_payload_len,
                      bus.m_desc_reth_valid, bus.m_desc_imm_valid}, {17'd0, snap_a});
                check("stall_hold_addr", bus.m_desc_rem_addr, snap_b);
                have_snap = 1'b0;
            end
            if (bus.m_desc_valid && bus.m_desc_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_desc", 64'd1, 64'd0);
                end else begin
                    d = q.pop_front();
                    check("opcode", 64'(bus.m_desc_opcode), 64'(d.op));
                    check("psn", 64'(bus.m_desc_psn), 64'(d.psn));
                    check("payload_len", 64'(bus.m_desc_payload_len), 64'(d.plen));
                    check("reth_valid", 64'(bus.m_desc_reth_valid), 64'(d.reth));
                    check("imm_valid", 64'(bus.m_desc_imm_valid), 64'(d.imm));
                    check("rem_addr", bus.m_desc_rem_addr, d.addr);
                    check("rkey_qpn", {8'd0, bus.m_desc_r_key, bus.m_desc_dest_qp}, {8'd0, d.rkey, d.qpn});
                    check("dma_ip", {bus.m_desc_dma_length, bus.m_desc_ip_addr}, {d.dma, d.ip});
                    if (d.imm) check("imm_data", 64'(bus.m_desc_imm_data), 64'(d.immd));
                end
            end else if (bus.m_desc_valid) begin
                snap_a    = {bus.m_desc_opcode, bus.m_desc_psn, bus.m_desc_payload_len,
                             bus.m_desc_reth_valid, bus.m_desc_imm_valid};
                snap_b    = bus.m_desc_rem_addr;
                have_snap = 1'b1;
            end
        end
    endtask

    // Reference split of one WR into expected descriptors.
    task automatic push_wr(input logic [31:0] len, input logic [23:0] psn0, input logic [2:0] code,
                           input logic imm, input logic [31:0] seed);
        int unsigned p, npk, rem;
        desc_t d;
        case (code)
            3'd1:    p = 256;
            3'd2:    p = 512;
            3'd3:    p = 1024;
            3'd4:    p = 2048;
            3'd5:    p = 4096;
            default: p = 1024;
        endcase
        npk = (len == 0) ? 1 : (len + p - 1) / p;
        for (int unsigned i = 0; i < npk; i++) begin
            rem    = len - i * p;
            d.plen = 13'((rem > p) ? p : rem);
            d.psn  = psn0 + 24'(i);
            if (i == 0) d.op = (i == npk - 1) ? (imm ? 8'h0B : 8'h0A) : 8'h06;
            else        d.op = (i == npk - 1) ? (imm ? 8'h09 : 8'h08) : 8'h07;
            d.reth = (i == 0);
            d.imm  = imm && (i == npk - 1);
            d.addr = {32'h1000_0000, seed};
            d.rkey = 32'hA000_0000 | seed;
            d.dma  = len;
            d.qpn  = 24'h001000 + seed[23:0];
            d.ip   = 32'hC0A8_0000 + seed;
            d.immd = imm ? 32'hDEADBEEF : seed * 3;
            q.push_back(d);
        end
        exp_np = psn0 + 24'(npk);
    endtask

    task automatic drive_cfg(input logic [31:0] len, input logic [23:0] psn0, input logic [2:0] code,
                             input logic imm, input logic [31:0] seed, input logic start);
        bus.cfg_dma_length  = len;
        bus.cfg_loc_psn     = psn0;
        bus.cfg_pmtu_code   = code;
        bus.cfg_write_imm   = imm;
        bus.cfg_rem_addr    = {32'h1000_0000, seed};
        bus.cfg_r_key       = 32'hA000_0000 | seed;
        bus.cfg_rem_qpn     = 24'h001000 + seed[23:0];
        bus.cfg_rem_ip_addr = 32'hC0A8_0000 + seed;
        bus.cfg_imm_data    = imm ? 32'hDEADBEEF : seed * 3;
        bus.cfg_valid       = 1'b1;
        bus.cfg_start       = start;
        step();
        bus.cfg_valid       = 1'b0;
        bus.cfg_start       = 1'b0;
    endtask

    task automatic run_wr(input string tag, input logic [31:0] len, input logic [23:0] psn0,
                          input logic [2:0] code, input logic imm, input logic [31:0] seed);
        push_wr(len, psn0, code, imm, seed);
        drive_cfg(len, psn0, code, imm, seed, 1'b1);
        drain(tag, 300);
        exp_done++;
        check({tag, "_wr_done_count"}, 64'(n_done), 64'(exp_done));
        check({tag, "_next_psn"}, 64'(bus.next_psn), 64'(exp_np));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q.size() != 0 || bus.busy) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 64'(q.size() == 0 && !bus.busy), 64'd1);
    endtask

    initial begin
        int n;
        bus.cfg_valid = 1'b0; bus.cfg_start = 1'b0; bus.cfg_write_imm = 1'b0;
        bus.cfg_dma_length = '0; bus.cfg_rem_addr = '0; bus.cfg_r_key = '0;
        bus.cfg_rem_qpn = '0; bus.cfg_loc_psn = '0; bus.cfg_rem_ip_addr = '0;
        bus.cfg_imm_data = '0; bus.cfg_pmtu_code = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.m_desc_valid), 64'd0);
        check("rst_opcode", 64'(bus.m_desc_opcode), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_next_psn", 64'(bus.next_psn), 64'd0);
        check("rst_pulses", 64'({bus.wr_done, bus.cfg_overrun}), 64'd0);
        rst = 1'b0;
        step();

        run_wr("len3000", 32'd3000, 24'h000010, 3'd3, 1'b0, 32'd1);
        check("len3000_next_psn_abs", 64'(bus.next_psn), 64'h13);
        run_wr("len1024", 32'd1024, 24'h000100, 3'd3, 1'b0, 32'd2);
        run_wr("len1025", 32'd1025, 24'h000200, 3'd3, 1'b0, 32'd3);
        run_wr("len0_imm", 32'd0, 24'h000300, 3'd3, 1'b1, 32'd4);
        run_wr("psn_wrap", 32'd1000, 24'hFFFFFE, 3'd1, 1'b0, 32'd5);
        check("psn_wrap_next_psn_abs", 64'(bus.next_psn), 64'h2);

        // Arm without start, start 5 cycles later, random stalls, overrun mid-send
        ready_mode = 1;
        push_wr(32'd3000, 24'h000400, 3'd1, 1'b1, 32'd6);
        drive_cfg(32'd3000, 24'h000400, 3'd1, 1'b1, 32'd6, 1'b0);
        check("armed_busy", 64'(bus.busy), 64'd1);
        check("armed_no_desc", 64'(bus.m_desc_valid), 64'd0);
        repeat (5) step();
        check("armed_still_idle_out", 64'(bus.m_desc_valid), 64'd0);
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        n = 0;
        while (q.size() > 9 && n < 200) begin step(); n++; end
        check("reach_mid_send", 64'(q.size() <= 9 && bus.busy), 64'd1);
        drive_cfg(32'd512, 24'h123456, 3'd2, 1'b0, 32'd99, 1'b1);
        drain("stall", 600);
        exp_done++;
        check("stall_wr_done_count", 64'(n_done), 64'(exp_done));
        check("stall_next_psn", 64'(bus.next_psn), 64'(exp_np));
        check("overrun_count", 64'(n_ovr), 64'd1);
        ready_mode = 0;
        step();

        // Reset after the 2nd of 4 descriptors, PMTU code 7 falls back to 1024 B
        push_wr(32'd4000, 24'h000500, 3'd7, 1'b0, 32'd7);
        drive_cfg(32'd4000, 24'h000500, 3'd7, 1'b0, 32'd7, 1'b1);
        n = 0;
        while (q.size() > 2 && n < 50) begin step(); n++; end
        check("rst_mid_two_sent", 64'(q.size()), 64'd2);
        ready_mode = 2;
        step();
        check("rst_mid_third_offered", 64'(bus.m_desc_valid), 64'd1);
        have_snap = 1'b0;
        rst = 1'b1;
        step();
        check("rst_mid_valid", 64'(bus.m_desc_valid), 64'd0);
        check("rst_mid_fields", 64'({bus.m_desc_opcode, bus.m_desc_psn, bus.m_desc_payload_len}), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_next_psn", 64'(bus.next_psn), 64'd0);
        rst = 1'b0;
        q.delete();
        repeat (3) step();
        check("rst_mid_no_wr_done", 64'(n_done), 64'(exp_done));
        ready_mode = 0;
        step();

        run_wr("after_rst", 32'd256, 24'h000600, 3'd2, 1'b0, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/roce_write_wr_scheduler.md
Name: roce_write_wr_scheduler

Overview:
- Sequences one RDMA WRITE work request into per-packet RoCEv2 header descriptors for the TX header/payload path.
- Consumes the QP and transfer metadata decoded from the UDP control channel.
- Splits the DMA length into PMTU-sized packets and assigns opcode, PSN, remote address and payload length to each.
- Emits one descriptor per packet on a valid/ready interface toward the RoCE TX framer.

Parameters:
- DEFAULT_PMTU_CODE, 3, PMTU code used when cfg_pmtu_code is 0, 6 or 7 (3 = 1024 B).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  one-cycle pulse; metadata fields below are valid
- cfg_start  in  1  start request, sampled with cfg_valid or later while ARMED
- cfg_write_imm  in  1  1 = use WRITE-with-immediate opcode on the LAST/ONLY packet
- cfg_dma_length  in  32  total bytes to write
- cfg_rem_addr  in  64  remote virtual address
- cfg_r_key  in  32  remote key
- cfg_rem_qpn  in  24  destination QP
- cfg_loc_psn  in  24  first PSN
- cfg_rem_ip_addr  in  32  destination IP
- cfg_imm_data  in  32  immediate data
- cfg_pmtu_code  in  3  1=256, 2=512, 3=1024, 4=2048, 5=4096 B
- m_desc_valid  out  1  descriptor valid
- m_desc_ready  in  1  downstream accept
- m_desc_opcode  out  8  BTH opcode
- m_desc_psn  out  24  packet PSN
- m_desc_dest_qp  out  24  latched rem_qpn
- m_desc_reth_valid  out  1  RETH present (FIRST/ONLY)
- m_desc_rem_addr  out  64  RETH VA; always the WR base address
- m_desc_r_key  out  32  RETH key
- m_desc_dma_length  out  32  RETH DMA length
- m_desc_imm_valid  out  1  ImmDt present
- m_desc_imm_data  out  32  immediate data
- m_desc_ip_addr  out  32  destination IP
- m_desc_payload_len  out  13  payload bytes in this packet
- next_psn  out  24  PSN after the last packet sent
- busy  out  1  state != IDLE
- wr_done  out  1  one-cycle pulse when the last descriptor is accepted
- cfg_overrun  out  1  one-cycle pulse when cfg_valid arrives while SEND

Behaviour:
- Reset values:
  - all outputs 0; next_psn = 0
  - state = IDLE; all internal registers 0
- Reset mid-operation aborts the WR immediately with no wr_done.

States and transitions:
- IDLE:
  - cfg_valid latches all cfg_* fields; remaining = cfg_dma_length; psn = cfg_loc_psn; first = 1.
  - If cfg_start = 1 in the same cycle, go to SEND; otherwise go to ARMED.
- ARMED:
  - cfg_start = 1 (with or without cfg_valid) goes to SEND.
  - cfg_valid without cfg_start re-latches all fields and stays in ARMED.
  - If cfg_valid and cfg_start are both 1, the new fields are latched before entering SEND.
- SEND:
  - m_desc_valid = 1, registered: asserted the cycle after entering SEND.
  - All m_desc_* outputs are held stable while m_desc_valid && !m_desc_ready.
  - On accept: psn = psn + 1 mod 2^24; remaining -= payload_len; first = 0.
  - The next descriptor is presented the following cycle, so back-to-back accepts give 1 descriptor/cycle.
  - After the accepted packet is LAST or ONLY: pulse wr_done, set next_psn = psn + 1 mod 2^24, go to IDLE.
  - cfg_valid in SEND is ignored, pulses cfg_overrun, and does not disturb the WR.

Per-packet fields:
- PMTU P = 256 << (code - 1). Invalid codes use DEFAULT_PMTU_CODE. Code is latched at cfg time.
- payload_len = min(remaining, P).
- Opcode selection:
  - first && remaining <= P: ONLY 0x0A, or 0x0B with imm.
  - first && remaining > P: FIRST 0x06.
  - !first && remaining > P: MIDDLE 0x07.
  - !first && remaining <= P: LAST 0x08, or 0x09 with imm.
- reth_valid = 1 on FIRST/ONLY only.
- imm_valid = 1 only on opcodes 0x09/0x0B.
- cfg_dma_length = 0: single ONLY packet, payload_len 0, reth dma_length 0.
- Packet count = ceil(len/P), or 1 when len = 0. remaining never underflows.
- PSN wraps 0xFFFFFF -> 0x000000 with no other effect.

Test Plan:
- PMTU code 3, len 3000, psn 0x000010, ready = 1 -> opcodes 06,07,08; PSNs 0x10,0x11,0x12; lengths 1024,1024,952; reth only on first; wr_done once; next_psn 0x13.
- len 1024 and len 1025 at PMTU 1024 -> 1024 gives one ONLY 0x0A (len 1024); 1025 gives FIRST(1024) then LAST(1).
- len 0, imm = 1, imm_data 0xDEADBEEF -> single 0x0B, payload 0, reth_valid = 1, imm_valid = 1.
- psn 0xFFFFFE, len 1000, PMTU code 1 -> PSNs 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; lengths 256,256,256,232; next_psn 0x000002.
- Random m_desc_ready stalls plus cfg_valid pulse mid-SEND -> outputs held stable during stalls; cfg_overrun pulses; sequence unchanged; cfg_valid without start in IDLE -> ARMED, cfg_start 5 cycles later starts the WR.
- rst asserted after the 2nd of 4 descriptors -> next cycle all outputs 0, IDLE, no wr_done; pmtu code 7 -> 1024 B packets.
